// File: rtl/qtcore_scan_pkg.sv
// Shared definitions for the scan chain driver: FSM state encoding and
// load-size helper.
package qtcore_scan_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_LOAD  = 2'd1,
    SCAN_SHIFT = 2'd2,
    SCAN_DONE  = 2'd3
  } scan_state_e;

  // Bytes needed to cover a chain of chain_len bits.
  function automatic int byte_cnt(input int chain_len);
    return (chain_len + 7) / 8;
  endfunction

endpackage

// File: rtl/scan_chain_driver_if.sv
// Byte streams between the host and the scan chain driver: configuration
// bytes in (wr_*) and captured readback bytes out (rd_*).
interface scan_chain_driver_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (
    output wr_data, wr_valid, rd_ready,
    input  wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  wr_data, wr_valid, rd_ready,
    output wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/scan_chain_driver_serdes.sv
// One byte of serialisation: parallel-in/serial-out for scan_in and
// serial-in/parallel-out capture of scan_out, over nbits_i active bits.
module scan_byte_serdes (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic [3:0] nbits_i,
  input  logic       shift_i,
  input  logic       sin_i,
  output logic       sout_o,
  output logic       last_o,
  output logic [7:0] cap_next_o
);
  logic [7:0] sh_q;
  logic [7:0] cap_q, cap_d;
  logic [3:0] cnt_q;
  logic [3:0] nbits_q;

  // Captured bit lands at the position equal to the number of bits already shifted.
  always_comb begin
    cap_d = cap_q;
    if (shift_i) cap_d = cap_q | (8'(sin_i) << cnt_q);
  end

  assign sout_o     = sh_q[0];
  assign last_o     = ((cnt_q + 4'd1) == nbits_q);
  assign cap_next_o = cap_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q    <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      nbits_q <= '0;
    end else if (load_i) begin
      sh_q    <= data_i;
      cap_q   <= '0;
      cnt_q   <= '0;
      nbits_q <= nbits_i;
    end else if (shift_i) begin
      sh_q  <= sh_q >> 1;
      cap_q <= cap_d;
      cnt_q <= cnt_q + 4'd1;
    end
  end
endmodule

// File: rtl/scan_chain_driver.sv
// Host-side scan chain initiator: streams bytes into the chain LSB first,
// returns the bits shifted out, and gates processor enable during a load.
module scan_chain_driver
  import qtcore_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 3
) (
  input  logic               clk,
  input  logic               rst,
  scan_chain_driver_if.slave bus,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               proc_enable_req,
  output logic               proc_enable_out,
  output logic               scan_enable,
  output logic               scan_in,
  input  logic               scan_out
);
  localparam int BYTE_CNT = byte_cnt(CHAIN_LEN);
  localparam int RW = ($clog2(CHAIN_LEN + 1) < 4) ? 4 : $clog2(CHAIN_LEN + 1);
  localparam int IW = (BYTE_CNT > 1) ? $clog2(BYTE_CNT) : 1;

  scan_state_e   state_q, state_d;
  logic [RW-1:0] bits_rem_q, bits_rem_d;
  logic [IW-1:0] byte_idx_q, byte_idx_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;

  logic       wr_ready;
  logic       load;
  logic       shift;
  logic       last;
  logic       sout;
  logic [3:0] nbits;
  logic [7:0] cap_next;

  assign nbits = (bits_rem_q >= RW'(8)) ? 4'd8 : bits_rem_q[3:0];

  always_comb begin
    state_d    = state_q;
    bits_rem_d = bits_rem_q;
    byte_idx_d = byte_idx_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    wr_ready   = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;

    if (rd_valid_q && bus.rd_ready) rd_valid_d = 1'b0;

    unique case (state_q)
      SCAN_IDLE: begin
        if (start && !rd_valid_q) begin
          state_d    = SCAN_LOAD;
          bits_rem_d = RW'(CHAIN_LEN);
          byte_idx_d = '0;
        end
      end
      SCAN_LOAD: begin
        // Only take a new byte once its readback slot is guaranteed free.
        wr_ready = !rd_valid_q || bus.rd_ready;
        if (bus.wr_valid && wr_ready) begin
          load       = 1'b1;
          bits_rem_d = bits_rem_q - RW'(nbits);
          state_d    = SCAN_SHIFT;
        end
      end
      SCAN_SHIFT: begin
        shift = 1'b1;
        if (last) begin
          rd_data_d  = cap_next;
          rd_valid_d = 1'b1;
          byte_idx_d = byte_idx_q + IW'(1);
          state_d    = (byte_idx_q == IW'(BYTE_CNT - 1)) ? SCAN_DONE : SCAN_LOAD;
        end
      end
      SCAN_DONE: state_d = SCAN_IDLE;
      default:   state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= SCAN_IDLE;
      bits_rem_q <= '0;
      byte_idx_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bits_rem_q <= bits_rem_d;
      byte_idx_q <= byte_idx_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  scan_byte_serdes u_serdes (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .data_i     (bus.wr_data),
    .nbits_i    (nbits),
    .shift_i    (shift),
    .sin_i      (scan_out),
    .sout_o     (sout),
    .last_o     (last),
    .cap_next_o (cap_next)
  );

  assign bus.wr_ready    = wr_ready;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign busy            = (state_q != SCAN_IDLE);
  assign done            = (state_q == SCAN_DONE);
  assign scan_enable     = shift;
  assign scan_in         = shift & sout;
  assign proc_enable_out = proc_enable_req & (state_q == SCAN_IDLE);
endmodule
